// File: rtl/cpu_bus_arbiter_if.sv
// Bundle of the fetch port, data port and shared Wishbone master signals
// seen by cpu_bus_arbiter; "slave" is the arbiter's view, "master" the environment's.
interface cpu_bus_arbiter_if;
    logic        iw_cyc_i;
    logic        iw_stb_i;
    logic [31:0] iw_adr_i;
    logic [31:0] iw_dat_o;
    logic        iw_ack_o;

    logic        dw_cyc_i;
    logic        dw_stb_i;
    logic        dw_we_i;
    logic [3:0]  dw_sel_i;
    logic [31:0] dw_adr_i;
    logic [31:0] dw_dat_i;
    logic [31:0] dw_dat_o;
    logic        dw_ack_o;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    logic [1:0]  grant_o;

    modport slave (
        input  iw_cyc_i, iw_stb_i, iw_adr_i,
        output iw_dat_o, iw_ack_o,
        input  dw_cyc_i, dw_stb_i, dw_we_i, dw_sel_i, dw_adr_i, dw_dat_i,
        output dw_dat_o, dw_ack_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i,
        output grant_o
    );

    modport master (
        output iw_cyc_i, iw_stb_i, iw_adr_i,
        input  iw_dat_o, iw_ack_o,
        output dw_cyc_i, dw_stb_i, dw_we_i, dw_sel_i, dw_adr_i, dw_dat_i,
        input  dw_dat_o, dw_ack_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i,
        input  grant_o
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Shares one Wishbone master port between instruction fetch and the data stage.
// Data wins ties, but fetch is forced through after STARVE_LIMIT consecutive data grants.
module cpu_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cpu_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_e;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_e     state_q;
    logic [7:0] starveCnt_q;

    // Every grant returns through IDLE, so handover always costs one idle cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            starveCnt_q <= 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.iw_cyc_i && (!bus.dw_cyc_i || starveCnt_q == LIMIT)) begin
                        state_q     <= GRANT_I;
                        starveCnt_q <= 8'd0;
                    end else if (bus.dw_cyc_i) begin
                        state_q <= GRANT_D;
                        if (bus.iw_cyc_i && starveCnt_q < LIMIT)
                            starveCnt_q <= starveCnt_q + 8'd1;
                    end
                end
                GRANT_I: if (!bus.iw_cyc_i) state_q <= IDLE;
                GRANT_D: if (!bus.dw_cyc_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant_o  = state_q;
    assign bus.iw_dat_o = bus.wb_dat_i;
    assign bus.dw_dat_o = bus.wb_dat_i;

    // The owner's ack follows wb_ack_i even in its cyc-drop cycle; IDLE ignores it.
    always_comb begin
        bus.wb_cyc_o = 1'b0;
        bus.wb_stb_o = 1'b0;
        bus.wb_we_o  = 1'b0;
        bus.wb_sel_o = 4'b0000;
        bus.wb_adr_o = 32'd0;
        bus.wb_dat_o = 32'd0;
        bus.iw_ack_o = 1'b0;
        bus.dw_ack_o = 1'b0;
        unique case (state_q)
            GRANT_I: begin
                bus.wb_cyc_o = bus.iw_cyc_i;
                bus.wb_stb_o = bus.iw_stb_i;
                bus.wb_sel_o = 4'b1111;
                bus.wb_adr_o = bus.iw_adr_i;
                bus.iw_ack_o = bus.wb_ack_i;
            end
            GRANT_D: begin
                bus.wb_cyc_o = bus.dw_cyc_i;
                bus.wb_stb_o = bus.dw_stb_i;
                bus.wb_we_o  = bus.dw_we_i;
                bus.wb_sel_o = bus.dw_sel_i;
                bus.wb_adr_o = bus.dw_adr_i;
                bus.wb_dat_o = bus.dw_dat_i;
                bus.dw_ack_o = bus.wb_ack_i;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: a cycle-by-cycle vector table followed by
// hand-written starvation and mid-grant reset sequences.
module tb_cpu_bus_arbiter;
    localparam logic [31:0] IW_ADR = 32'h0000_0400;
    localparam logic [31:0] DW_ADR = 32'h0000_1000;
    localparam logic [31:0] DW_DAT = 32'hDEAD_BEEF;

    typedef struct {
        logic        iwCyc, iwStb, dwCyc, dwStb, dwWe;
        logic [3:0]  dwSel;
        logic        wbAck;
        logic [31:0] wbDat;
        logic [1:0]  expGrant;
        logic        expCyc, expStb, expWe;
        logic [3:0]  expSel;
        logic        expIwAck, expDwAck;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    cpu_bus_arbiter_if bus();

    cpu_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic iwc, input logic iws, input logic dwc, input logic dws,
        input logic we, input logic [3:0] sel, input logic ack, input logic [31:0] wbd,
        input logic [1:0] eg, input logic ec, input logic es, input logic ew,
        input logic [3:0] esel, input logic eia, input logic eda);
        vec_t v;
        v.iwCyc = iwc; v.iwStb = iws; v.dwCyc = dwc; v.dwStb = dws; v.dwWe = we;
        v.dwSel = sel; v.wbAck = ack; v.wbDat = wbd;
        v.expGrant = eg; v.expCyc = ec; v.expStb = es; v.expWe = ew;
        v.expSel = esel; v.expIwAck = eia; v.expDwAck = eda;
        return v;
    endfunction

    task automatic applyStimulus(
        input logic iwc, input logic iws, input logic dwc, input logic dws,
        input logic we, input logic [3:0] sel, input logic ack, input logic [31:0] wbd);
        bus.iw_cyc_i = iwc;
        bus.iw_stb_i = iws;
        bus.iw_adr_i = IW_ADR;
        bus.dw_cyc_i = dwc;
        bus.dw_stb_i = dws;
        bus.dw_we_i  = we;
        bus.dw_sel_i = sel;
        bus.dw_adr_i = DW_ADR;
        bus.dw_dat_i = DW_DAT;
        bus.wb_dat_i = wbd;
        bus.wb_ack_i = ack;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        chk({tag, " grant"},  32'(bus.grant_o),  32'(v.expGrant));
        chk({tag, " wbCyc"},  32'(bus.wb_cyc_o), 32'(v.expCyc));
        chk({tag, " wbStb"},  32'(bus.wb_stb_o), 32'(v.expStb));
        chk({tag, " wbWe"},   32'(bus.wb_we_o),  32'(v.expWe));
        chk({tag, " wbSel"},  32'(bus.wb_sel_o), 32'(v.expSel));
        chk({tag, " iwAck"},  32'(bus.iw_ack_o), 32'(v.expIwAck));
        chk({tag, " dwAck"},  32'(bus.dw_ack_o), 32'(v.expDwAck));
        chk({tag, " iwDat"},  bus.iw_dat_o, v.wbDat);
        chk({tag, " dwDat"},  bus.dw_dat_o, v.wbDat);
        if (v.expGrant == 2'b01)
            chk({tag, " wbAdrI"}, bus.wb_adr_o, IW_ADR);
        if (v.expGrant == 2'b10) begin
            chk({tag, " wbAdrD"}, bus.wb_adr_o, DW_ADR);
            chk({tag, " wbDatO"}, bus.wb_dat_o, DW_DAT);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One complete two-cycle transaction with both sides requesting in IDLE.
    task automatic runGrant(input string tag, input logic [1:0] eg);
        applyStimulus(1, 1, 1, 1, 0, 4'hF, 0, 32'h0);
        @(negedge clk);
        chk({tag, " idle grant"}, 32'(bus.grant_o), 32'd0);
        chk({tag, " idle wbCyc"}, 32'(bus.wb_cyc_o), 32'd0);
        chk({tag, " idle wbSel"}, 32'(bus.wb_sel_o), 32'd0);
        nextCycle();
        applyStimulus(1, 1, 1, 1, 0, 4'hF, 1, 32'h0);
        @(negedge clk);
        chk({tag, " grant"}, 32'(bus.grant_o), 32'(eg));
        chk({tag, " iwAck"}, 32'(bus.iw_ack_o), 32'(eg == 2'b01));
        chk({tag, " dwAck"}, 32'(bus.dw_ack_o), 32'(eg == 2'b10));
        nextCycle();
        if (eg == 2'b10) applyStimulus(1, 1, 0, 0, 0, 4'hF, 0, 32'h0);
        else             applyStimulus(0, 0, 1, 1, 0, 4'hF, 0, 32'h0);
        @(negedge clk);
        chk({tag, " hold grant"}, 32'(bus.grant_o), 32'(eg));
        chk({tag, " drop wbCyc"}, 32'(bus.wb_cyc_o), 32'd0);
        nextCycle();
    endtask

    vec_t vecs[16];
    logic [1:0] order[10];
    logic [1:0] afterReset[5];

    initial begin
        vecs[0]  = mk(0,0,0,0,0,4'h0,1,32'hA5A5_0001, 2'd0,0,0,0,4'h0,0,0);
        vecs[1]  = mk(0,0,1,1,1,4'hF,0,32'hA5A5_0001, 2'd0,0,0,0,4'h0,0,0);
        vecs[2]  = mk(0,0,1,1,1,4'hF,0,32'hA5A5_0001, 2'd2,1,1,1,4'hF,0,0);
        vecs[3]  = mk(0,0,1,1,1,4'hF,1,32'h1234_5678, 2'd2,1,1,1,4'hF,0,1);
        vecs[4]  = mk(0,0,0,0,1,4'hF,0,32'hA5A5_0001, 2'd2,0,0,1,4'hF,0,0);
        vecs[5]  = mk(0,0,0,0,0,4'h0,0,32'hA5A5_0001, 2'd0,0,0,0,4'h0,0,0);
        vecs[6]  = mk(1,1,0,0,0,4'h0,0,32'h0BAD_F00D, 2'd0,0,0,0,4'h0,0,0);
        vecs[7]  = mk(1,1,1,1,1,4'h3,0,32'h0BAD_F00D, 2'd1,1,1,0,4'hF,0,0);
        vecs[8]  = mk(1,1,1,1,1,4'h3,1,32'h1111_0001, 2'd1,1,1,0,4'hF,1,0);
        vecs[9]  = mk(1,0,1,1,1,4'h3,0,32'h1111_0001, 2'd1,1,0,0,4'hF,0,0);
        vecs[10] = mk(1,1,1,1,1,4'h3,1,32'h2222_0002, 2'd1,1,1,0,4'hF,1,0);
        vecs[11] = mk(0,0,1,1,1,4'h3,1,32'h3333_0003, 2'd1,0,0,0,4'hF,1,0);
        vecs[12] = mk(0,0,1,1,1,4'h3,1,32'h3333_0003, 2'd0,0,0,0,4'h0,0,0);
        vecs[13] = mk(0,0,1,1,1,4'h3,0,32'h4444_0004, 2'd2,1,1,1,4'h3,0,0);
        vecs[14] = mk(0,0,0,0,0,4'h3,0,32'h4444_0004, 2'd2,0,0,0,4'h3,0,0);
        vecs[15] = mk(0,0,0,0,0,4'h0,0,32'h5555_0005, 2'd0,0,0,0,4'h0,0,0);
        order      = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
        afterReset = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

        applyStimulus(0, 0, 0, 0, 0, 4'h0, 0, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].iwCyc, vecs[i].iwStb, vecs[i].dwCyc, vecs[i].dwStb,
                          vecs[i].dwWe, vecs[i].dwSel, vecs[i].wbAck, vecs[i].wbDat);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
            nextCycle();
        end

        for (int g = 0; g < 10; g++)
            runGrant($sformatf("starve%0d", g), order[g]);

        applyStimulus(1, 1, 1, 1, 1, 4'hF, 0, 32'h0);
        @(negedge clk);
        chk("rstSeq idle grant", 32'(bus.grant_o), 32'd0);
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rstSeq pre grant", 32'(bus.grant_o), 32'd2);
        chk("rstSeq pre wbCyc", 32'(bus.wb_cyc_o), 32'd1);
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 4'h0, 1, 32'h0);
        @(negedge clk);
        chk("rstSeq post grant", 32'(bus.grant_o), 32'd0);
        chk("rstSeq post wbCyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("rstSeq post wbSel", 32'(bus.wb_sel_o), 32'd0);
        chk("rstSeq post iwAck", 32'(bus.iw_ack_o), 32'd0);
        chk("rstSeq post dwAck", 32'(bus.dw_ack_o), 32'd0);
        nextCycle();

        // A cleared counter allows a full four data grants before fetch wins.
        for (int g = 0; g < 5; g++)
            runGrant($sformatf("postRst%0d", g), afterReset[g]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive data-side grants allowed while fetch is waiting, before fetch is forced through.
REQ-002 The block SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port iw_cyc_i  input  1  fetch-side cycle request.
REQ-005 The block SHALL have port iw_stb_i  input  1  fetch-side strobe.
REQ-006 The block SHALL have port iw_adr_i  input  32  fetch address (read only).
REQ-007 The block SHALL have port iw_dat_o  output  32  fetch read data.
REQ-008 The block SHALL have port iw_ack_o  output  1  fetch acknowledge.
REQ-009 The block SHALL have port dw_cyc_i  input  1  data-side (memory stage) cycle request.
REQ-010 The block SHALL have port dw_stb_i  input  1  data-side strobe.
REQ-011 The block SHALL have port dw_we_i  input  1  data-side write enable.
REQ-012 The block SHALL have port dw_sel_i  input  4  data-side byte selects.
REQ-013 The block SHALL have port dw_adr_i  input  32  data-side address.
REQ-014 The block SHALL have port dw_dat_i  input  32  data-side write data.
REQ-015 The block SHALL have port dw_dat_o  output  32  data-side read data.
REQ-016 The block SHALL have port dw_ack_o  output  1  data-side acknowledge.
REQ-017 The block SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  shared Wishbone master controls.
REQ-018 The block SHALL have ports wb_sel_o  output  4, and wb_adr_o and wb_dat_o  output  32 each  shared Wishbone master selects, address and write data.
REQ-019 The block SHALL have ports wb_dat_i  input  32 and wb_ack_i  input  1  shared Wishbone slave response.
REQ-020 The block SHALL have port grant_o  output  2  current owner of the shared bus: 00 none, 01 fetch, 10 data.

Function
REQ-021 The block SHALL implement states IDLE, GRANT_I and GRANT_D; grant_o SHALL encode the state (00, 01, 10 respectively).
REQ-022 In IDLE: wb_cyc_o, wb_stb_o, wb_we_o, iw_ack_o and dw_ack_o SHALL be 0, wb_sel_o SHALL be 0000, and wb_ack_i SHALL be ignored.
REQ-023 Arbitration latency SHALL be one cycle: a cyc_i sampled high in IDLE moves the state to GRANT_x at the next edge.
REQ-024 In IDLE, if only iw_cyc_i is high, the next state SHALL be GRANT_I; if only dw_cyc_i is high, the next state SHALL be GRANT_D.
REQ-025 In IDLE, if both are high, the next state SHALL be GRANT_D unless the starve counter equals STARVE_LIMIT, in which case the next state SHALL be GRANT_I.
REQ-026 In GRANT_x, all wb_*_o signals SHALL be driven combinationally from the owner's inputs; in GRANT_I, wb_we_o=0 and wb_sel_o=1111.
REQ-027 wb_ack_i SHALL be routed combinationally only to the owner's ack_o; the non-owner's ack SHALL stay 0.
REQ-028 wb_dat_i SHALL drive both iw_dat_o and dw_dat_o unconditionally.
REQ-029 Ownership SHALL persist while the owner's cyc_i is high, across any number of stb/ack beats; when the owner's cyc_i is sampled low, the next state SHALL be IDLE.
REQ-030 A minimum of one IDLE cycle SHALL separate consecutive grants; there SHALL be no back-to-back handover.
REQ-031 The starve counter SHALL be 8 bits wide. It SHALL increment on each IDLE->GRANT_D transition taken while iw_cyc_i is high, saturating at STARVE_LIMIT; it SHALL clear on each IDLE->GRANT_I transition.
REQ-032 A wb_ack_i arriving in the same cycle as the owner drops cyc_i SHALL still be forwarded to the owner.

Reset
REQ-033 When rst_i is sampled high, state SHALL become IDLE and the starve counter SHALL become 0, overriding all other transitions including a mid-transaction grant.
REQ-034 After a reset edge, all outputs SHALL take IDLE values (REQ-022, grant_o=00); wb_adr_o, wb_dat_o, iw_dat_o and dw_dat_o are don't-care in IDLE.

Verification
REQ-035 Scenario: dw_cyc_i=dw_stb_i=1, write to 0x1000 with data 0xDEADBEEF and sel 1111 -> one IDLE cycle, then grant_o=10 and wb_* mirror the request; wb_ack_i pulse -> dw_ack_o pulses and iw_ack_o stays 0; cyc drop -> IDLE.
REQ-036 Scenario: iw and dw both request continuously, each transaction lasting 2 cycles, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,...; the counter clears after the I grant.
REQ-037 Scenario: fetch burst with iw_cyc_i held for 3 acks while dw_cyc_i rises mid-burst -> grant_o stays 01 through all 3 acks, then IDLE, then 10.
REQ-038 Scenario: rst_i asserted during GRANT_D with stb high -> next cycle grant_o=00, wb_cyc_o=0, counter=0; a subsequent wb_ack_i is not forwarded.
REQ-039 Scenario: wb_ack_i asserted while IDLE -> iw_ack_o=dw_ack_o=0; ack coincident with owner cyc drop -> ack forwarded, then IDLE.
